// File: rtl/alu_share_arbiter.sv
// Purpose: lets two requesters share one combinational RV32I ALU, one operation per cycle.
// Latency: a request accepted in cycle N shows its result on rspi_result in cycle N+1.
// Backpressure: a port is refused while its one-entry response register is full and not draining.
//
// Ports:
//   clk, rst                      rising-edge clock, asynchronous active-high reset
//   req{0,1}_valid/op/a/b/ready   request channels (port 0 = integer pipe, port 1 = address/aux)
//   rsp{0,1}_valid/result/ready   response channels, one registered entry per port
//   alu_op/alu_a/alu_b            operands to the shared ALU (zero when nothing is granted)
//   alu_result                    combinational result back from the ALU
//   op_count                      accepted operations, wraps modulo 2^CNT_W
//   err_illegal_op                sticky flag for an accepted unsupported opcode
module alu_share_arbiter #(
  parameter int unsigned RR_ENABLE = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [4:0]       req0_op,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  output logic             req0_ready,
  output logic             rsp0_valid,
  output logic [31:0]      rsp0_result,
  input  logic             rsp0_ready,
  input  logic             req1_valid,
  input  logic [4:0]       req1_op,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  output logic             req1_ready,
  output logic             rsp1_valid,
  output logic [31:0]      rsp1_result,
  input  logic             rsp1_ready,
  output logic [4:0]       alu_op,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_result,
  output logic [CNT_W-1:0] op_count,
  output logic             err_illegal_op
);

  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [31:0]      rsp0_result_q, rsp0_result_d;
  logic [31:0]      rsp1_result_q, rsp1_result_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             err_q, err_d;
  // 0 = port 0 won the last transfer, 1 = port 1 did.
  logic             last_grant_q, last_grant_d;

  logic elig0, elig1;
  logic grant0, grant1;
  logic op_legal;

  // A full response register that drains this cycle frees its slot for the
  // new result, so rspi_ready feeds reqi_ready combinationally.
  assign elig0 = req0_valid && (!rsp0_valid_q || rsp0_ready);
  assign elig1 = req1_valid && (!rsp1_valid_q || rsp1_ready);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (elig0 && elig1) begin
      if (RR_ENABLE != 0) begin
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else begin
        grant0 = 1'b1;
      end
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    alu_op = 5'd0;
    alu_a  = 32'd0;
    alu_b  = 32'd0;
    if (grant0) begin
      alu_op = req0_op;
      alu_a  = req0_a;
      alu_b  = req0_b;
    end else if (grant1) begin
      alu_op = req1_op;
      alu_a  = req1_a;
      alu_b  = req1_b;
    end
  end

  // Only the granted op reaches alu_op, and the idle value 0 is legal, so
  // checking alu_op on a transfer covers both ports.
  always_comb begin
    op_legal = 1'b0;
    case (alu_op)
      5'h00, 5'h01, 5'h02, 5'h03, 5'h04,
      5'h05, 5'h06, 5'h07, 5'h08, 5'h0D: op_legal = 1'b1;
      default:                           op_legal = 1'b0;
    endcase
  end

  always_comb begin
    rsp0_valid_d  = rsp0_valid_q;
    rsp1_valid_d  = rsp1_valid_q;
    rsp0_result_d = rsp0_result_q;
    rsp1_result_d = rsp1_result_q;
    op_count_d    = op_count_q;
    err_d         = err_q;
    last_grant_d  = last_grant_q;

    // Drain first; a same-cycle transfer below overrides it so there is no bubble.
    if (rsp0_ready) rsp0_valid_d = 1'b0;
    if (rsp1_ready) rsp1_valid_d = 1'b0;

    if (grant0) begin
      rsp0_valid_d  = 1'b1;
      rsp0_result_d = alu_result;
      last_grant_d  = 1'b0;
    end
    if (grant1) begin
      rsp1_valid_d  = 1'b1;
      rsp1_result_d = alu_result;
      last_grant_d  = 1'b1;
    end
    if (grant0 || grant1) begin
      op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (!op_legal) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_result_q <= 32'd0;
      rsp1_result_q <= 32'd0;
      op_count_q    <= '0;
      err_q         <= 1'b0;
      last_grant_q  <= 1'b1;
    end else begin
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp1_result_q <= rsp1_result_d;
      op_count_q    <= op_count_d;
      err_q         <= err_d;
      last_grant_q  <= last_grant_d;
    end
  end

  assign rsp0_valid     = rsp0_valid_q;
  assign rsp1_valid     = rsp1_valid_q;
  assign rsp0_result    = rsp0_result_q;
  assign rsp1_result    = rsp1_result_q;
  assign op_count       = op_count_q;
  assign err_illegal_op = err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Purpose: exercises alu_share_arbiter (round-robin and fixed-priority builds) against a reference ALU.
// Latency: results are scoreboarded when each response handshake completes.
// Backpressure: rsp_ready is driven low in chosen windows to hold responses.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [4:0]  req0_op = 5'd0, req1_op = 5'd0;
  logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;

  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_result, rsp1_result;
  logic [4:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [15:0] op_count;
  logic        err_illegal_op;

  logic        fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid;
  logic [31:0] fp_rsp0_result, fp_rsp1_result;
  logic [4:0]  fp_alu_op;
  logic [31:0] fp_alu_a, fp_alu_b, fp_alu_result;
  logic [15:0] fp_op_count;
  logic        fp_err_illegal_op;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp0[$];
  logic [31:0] exp1[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'h00:   return a + b;
      5'h01:   return a << b[4:0];
      5'h02:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'h03:   return (a < b) ? 32'd1 : 32'd0;
      5'h04:   return a ^ b;
      5'h05:   return a >> b[4:0];
      5'h06:   return a | b;
      5'h07:   return a & b;
      5'h08:   return a - b;
      5'h0D:   return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result    = alu_ref(alu_op, alu_a, alu_b);
  assign fp_alu_result = alu_ref(fp_alu_op, fp_alu_a, fp_alu_b);

  alu_share_arbiter #(.RR_ENABLE(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_ready(rsp1_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .op_count(op_count), .err_illegal_op(err_illegal_op)
  );

  alu_share_arbiter #(.RR_ENABLE(0), .CNT_W(16)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(fp_req0_ready),
    .rsp0_valid(fp_rsp0_valid), .rsp0_result(fp_rsp0_result), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(fp_req1_ready),
    .rsp1_valid(fp_rsp1_valid), .rsp1_result(fp_rsp1_result), .rsp1_ready(rsp1_ready),
    .alu_op(fp_alu_op), .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_result(fp_alu_result),
    .op_count(fp_op_count), .err_illegal_op(fp_err_illegal_op)
  );

  // Scoreboard for the round-robin instance: the result being drained is
  // compared before the newly accepted request's expectation is queued.
  always @(negedge clk) begin
    if (rst) begin
      exp0.delete();
      exp1.delete();
    end else begin
      if (rsp0_valid && rsp0_ready) begin
        n_checks++;
        if (exp0.size() == 0) $display("FAIL sb0_unexpected got %08h want none", rsp0_result);
        else begin
          if (rsp0_result !== exp0[0]) $display("FAIL sb0_result got %08h want %08h", rsp0_result, exp0[0]);
          else n_pass++;
          void'(exp0.pop_front());
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        n_checks++;
        if (exp1.size() == 0) $display("FAIL sb1_unexpected got %08h want none", rsp1_result);
        else begin
          if (rsp1_result !== exp1[0]) $display("FAIL sb1_result got %08h want %08h", rsp1_result, exp1[0]);
          else n_pass++;
          void'(exp1.pop_front());
        end
      end
      if (req0_valid && req0_ready) exp0.push_back(alu_ref(req0_op, req0_a, req0_b));
      if (req1_valid && req1_ready) exp1.push_back(alu_ref(req1_op, req1_a, req1_b));
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) $display("FAIL reset_valid got %b%b want 00", rsp0_valid, rsp1_valid); else n_pass++;
    n_checks++; if (rsp0_result !== 32'd0 || rsp1_result !== 32'd0) $display("FAIL reset_result got %08h/%08h want 0/0", rsp0_result, rsp1_result); else n_pass++;
    n_checks++; if (op_count !== 16'd0 || err_illegal_op !== 1'b0) $display("FAIL reset_cnt_err got %0d/%b want 0/0", op_count, err_illegal_op); else n_pass++;
    n_checks++; if (alu_op !== 5'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) $display("FAIL reset_alu_idle got %0h/%08h/%08h want 0/0/0", alu_op, alu_a, alu_b); else n_pass++;
    do_reset();
  endtask

  task automatic test_single_op();
    do_reset();
    req0_op = 5'h00; req0_a = 32'h5; req0_b = 32'h3; req0_valid = 1'b1;
    #1;
    n_checks++; if (req0_ready !== 1'b1) $display("FAIL single_ready got %b want 1", req0_ready); else n_pass++;
    n_checks++; if (alu_a !== 32'h5 || alu_b !== 32'h3) $display("FAIL single_alu_drive got %08h/%08h want 5/3", alu_a, alu_b); else n_pass++;
    @(posedge clk); #1 req0_valid = 1'b0;
    #1;
    n_checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'h8) $display("FAIL single_rsp got %b/%08h want 1/00000008", rsp0_valid, rsp0_result); else n_pass++;
    n_checks++; if (op_count !== 16'd1) $display("FAIL single_count got %0d want 1", op_count); else n_pass++;
    n_checks++; if (alu_op !== 5'd0 || alu_a !== 32'd0) $display("FAIL single_alu_idle got %0h/%08h want 0/0", alu_op, alu_a); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (rsp0_valid !== 1'b0 || rsp0_result !== 32'h8) $display("FAIL single_drain got %b/%08h want 0/00000008", rsp0_valid, rsp0_result); else n_pass++;
  endtask

  task automatic test_round_robin();
    do_reset();
    req0_op = 5'h00; req0_a = 32'h1234; req0_b = 32'h1111; req0_valid = 1'b1;
    req1_op = 5'h04; req1_a = 32'hF0F0_0000; req1_b = 32'h0F0F_FFFF; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (req0_ready !== !k[0] || req1_ready !== k[0]) $display("FAIL rr_grant_%0d got %b%b want %b%b", k, req0_ready, req1_ready, !k[0], k[0]); else n_pass++;
      n_checks++; if (rsp0_valid !== k[0] || rsp1_valid !== (k != 0 && !k[0])) $display("FAIL rr_rsp_valid_%0d got %b%b want %b%b", k, rsp0_valid, rsp1_valid, k[0], (k != 0 && !k[0])); else n_pass++;
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    n_checks++; if (op_count !== 16'd4) $display("FAIL rr_count got %0d want 4", op_count); else n_pass++;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_fixed_priority();
    do_reset();
    req0_op = 5'h07; req0_a = 32'hFF00_FF00; req0_b = 32'h0FF0_0FF0; req0_valid = 1'b1;
    req1_op = 5'h06; req1_a = 32'h1; req1_b = 32'h2; req1_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (fp_req0_ready !== 1'b1 || fp_req1_ready !== 1'b0) $display("FAIL fp_grant_%0d got %b%b want 10", k, fp_req0_ready, fp_req1_ready); else n_pass++;
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    n_checks++; if (fp_op_count !== 16'd3 || fp_rsp0_result !== 32'h0F00_0F00) $display("FAIL fp_count_result got %0d/%08h want 3/0f000f00", fp_op_count, fp_rsp0_result); else n_pass++;
    n_checks++; if (fp_rsp1_valid !== 1'b0) $display("FAIL fp_port1_idle got %b want 0", fp_rsp1_valid); else n_pass++;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_backpressure();
    do_reset();
    req0_op = 5'h08; req0_a = 32'h10; req0_b = 32'h1; req0_valid = 1'b1;
    #1;
    n_checks++; if (req0_ready !== 1'b1) $display("FAIL bp_first_ready got %b want 1", req0_ready); else n_pass++;
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    req0_op = 5'h00; req0_a = 32'h2; req0_b = 32'h2;
    req1_op = 5'h0D; req1_a = 32'h8000_0000; req1_b = 32'h4; req1_valid = 1'b1;
    #1;
    n_checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'hF) $display("FAIL bp_first_rsp got %b/%08h want 1/0000000f", rsp0_valid, rsp0_result); else n_pass++;
    n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) $display("FAIL bp_block got %b%b want 01", req0_ready, req1_ready); else n_pass++;
    @(posedge clk); #1 req1_valid = 1'b0;
    #1;
    n_checks++; if (rsp0_result !== 32'hF || req0_ready !== 1'b0) $display("FAIL bp_hold got %08h/%b want 0000000f/0", rsp0_result, req0_ready); else n_pass++;
    n_checks++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'hF800_0000) $display("FAIL bp_sra got %b/%08h want 1/f8000000", rsp1_valid, rsp1_result); else n_pass++;
    rsp0_ready = 1'b1;
    #1;
    n_checks++; if (req0_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", req0_ready); else n_pass++;
    @(posedge clk); #1 req0_valid = 1'b0;
    #1;
    n_checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'h4) $display("FAIL bp_no_bubble got %b/%08h want 1/00000004", rsp0_valid, rsp0_result); else n_pass++;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_illegal_op();
    do_reset();
    req1_op = 5'h09; req1_a = 32'h5; req1_b = 32'h3; req1_valid = 1'b1;
    #1;
    n_checks++; if (err_illegal_op !== 1'b0) $display("FAIL ill_before got %b want 0", err_illegal_op); else n_pass++;
    @(posedge clk); #1;
    req1_op = 5'h00; req1_a = 32'h1; req1_b = 32'h2;
    #1;
    n_checks++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'd0 || err_illegal_op !== 1'b1) $display("FAIL ill_flag got %b/%08h/%b want 1/00000000/1", rsp1_valid, rsp1_result, err_illegal_op); else n_pass++;
    @(posedge clk); #1 req1_valid = 1'b0;
    #1;
    n_checks++; if (rsp1_result !== 32'h3 || err_illegal_op !== 1'b1) $display("FAIL ill_sticky got %08h/%b want 00000003/1", rsp1_result, err_illegal_op); else n_pass++;
    repeat (3) @(posedge clk); #1;
    n_checks++; if (err_illegal_op !== 1'b1) $display("FAIL ill_sticky_idle got %b want 1", err_illegal_op); else n_pass++;
  endtask

  task automatic test_wrap_reset();
    do_reset();
    req0_op = 5'h00; req0_b = 32'h1; req0_a = 32'd0; req0_valid = 1'b1;
    for (int i = 1; i < 65536; i++) begin
      @(posedge clk); #1 req0_a = i;
    end
    #1;
    n_checks++; if (op_count !== 16'hFFFF) $display("FAIL wrap_preload got %0d want 65535", op_count); else n_pass++;
    @(posedge clk); #1 req0_valid = 1'b0;
    #1;
    n_checks++; if (op_count !== 16'd0) $display("FAIL wrap_zero got %0d want 0", op_count); else n_pass++;
    req1_op = 5'h0A; req1_a = 32'h7; req1_b = 32'h7; req1_valid = 1'b1;
    @(posedge clk); #1 req1_valid = 1'b0; rsp1_ready = 1'b0;
    #1;
    n_checks++; if (rsp1_valid !== 1'b1 || err_illegal_op !== 1'b1) $display("FAIL wrap_pending got %b/%b want 1/1", rsp1_valid, err_illegal_op); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (rsp1_valid !== 1'b0 || err_illegal_op !== 1'b0) $display("FAIL async_reset got %b/%b want 0/0", rsp1_valid, err_illegal_op); else n_pass++;
    n_checks++; if (op_count !== 16'd0 || rsp1_result !== 32'd0) $display("FAIL async_reset_state got %0d/%08h want 0/0", op_count, rsp1_result); else n_pass++;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0; rsp1_ready = 1'b1;
    req0_op = 5'h01; req0_a = 32'h1; req0_b = 32'h1F; req0_valid = 1'b1;
    req1_op = 5'h03; req1_a = 32'h1; req1_b = 32'hFFFF_FFFF; req1_valid = 1'b1;
    #1;
    n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL post_reset_tie got %b%b want 10", req0_ready, req1_ready); else n_pass++;
    @(posedge clk); #1 req0_valid = 1'b0;
    @(posedge clk); #1 req1_valid = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL timeout got running want finished");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_op();
    test_round_robin();
    test_fixed_priority();
    test_backpressure();
    test_illegal_op();
    test_wrap_reset();
    #1;
    n_checks++; if (exp0.size() != 0 || exp1.size() != 0) $display("FAIL sb_leftover got %0d/%0d want 0/0", exp0.size(), exp1.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit RV32I ALU between two requesters, port 0 (integer pipeline) and port 1 (address/aux unit).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The arbiter drives the ALU operands and captures the ALU result into a per-port one-entry response register.
- Also provides an operation counter and a sticky illegal-opcode flag for debug.

Parameters:
- RR_ENABLE, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 always wins.
- CNT_W, 16, width of the accepted-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  port 0 request valid.
- req0_op  in  5  port 0 ALU opcode.
- req0_a  in  32  port 0 operand a.
- req0_b  in  32  port 0 operand b.
- req0_ready  out  1  port 0 request accepted this cycle.
- rsp0_valid  out  1  port 0 result valid.
- rsp0_result  out  32  port 0 result.
- rsp0_ready  in  1  port 0 consumer ready.
- req1_valid, req1_op, req1_a, req1_b, req1_ready, rsp1_valid, rsp1_result, rsp1_ready: same as port 0, for port 1.
- alu_op  out  5  to ALU op.
- alu_a  out  32  to ALU a.
- alu_b  out  32  to ALU b.
- alu_result  in  32  from ALU result.
- op_count  out  CNT_W  accepted operations, wraps modulo 2^CNT_W.
- err_illegal_op  out  1  sticky; set when an unsupported opcode is accepted.

Behaviour:
- Reset values (asynchronous, on rst high): rsp0_valid=0, rsp1_valid=0, rsp0_result=0, rsp1_result=0, op_count=0, err_illegal_op=0, last_grant=1 (so port 0 wins the first tie).
- Eligibility:
  - elig_i = reqi_valid && (!rspi_valid || rspi_ready).
  - A port cannot be granted while its response register is full and not draining this cycle.
- Grant (combinational, at most one per cycle):
  - Only one port eligible -> grant it.
  - Both eligible, RR_ENABLE=1 -> grant the port != last_grant.
  - Both eligible, RR_ENABLE=0 -> grant port 0.
  - reqi_ready = grant_i.
  - reqi_ready may depend on rspi_ready (combinational path, documented).
- ALU drive:
  - alu_op/alu_a/alu_b = the granted port's op/a/b.
  - No grant -> alu_op=5'd0, alu_a=0, alu_b=0.
- Transfer on port i = reqi_valid && reqi_ready. On a transfer edge:
  - rspi_result <= alu_result and rspi_valid <= 1.
  - last_grant <= i.
  - op_count increments by 1 and wraps at all-ones -> 0.
- Latency: request accepted in cycle N -> rspi_valid=1 with result in cycle N+1. Aggregate throughput is 1 op/cycle.
- Response hold: while rspi_valid && !rspi_ready, rspi_result is stable and port i is not granted.
- Drain: rspi_valid && rspi_ready with no new transfer on port i -> rspi_valid <= 0. rspi_result keeps its last value.
- Simultaneous drain and new transfer on the same port: rspi_valid stays 1 and rspi_result is replaced by the new result. No bubble.
- last_grant changes only on a transfer. Idle cycles do not alter priority.
- Legal opcodes: 0x00 ADD, 0x01 SLL, 0x02 SLT, 0x03 SLTU, 0x04 XOR, 0x05 SRL, 0x06 OR, 0x07 AND, 0x08 SUB, 0x0D SRA.
  - Any other accepted opcode sets err_illegal_op=1 until reset.
  - The ALU result (0 for an unknown op) is still returned normally.
- reqi_op/a/b must be stable while reqi_valid && !reqi_ready. The arbiter does not check this.
- Reset asserted mid-operation: all pending responses are discarded immediately (asynchronously). The first post-reset tie goes to port 0.

Test Plan:
- Single op: port 0 ADD a=0x0000_0005, b=0x0000_0003 -> req0_ready=1 same cycle; rsp0_valid=1, rsp0_result=0x0000_0008 next cycle; op_count=1.
- Round-robin contention: both ports valid every cycle, both rsp_ready=1, RR_ENABLE=1 -> grants alternate 0,1,0,1 starting with port 0. Each port gets one result every 2 cycles; op_count=4 after 4 cycles.
- Fixed priority: RR_ENABLE=0, both valid for 3 cycles -> port 0 granted 3 times, req1_ready=0 throughout.
- Backpressure: rsp0_ready=0 after the first result (SUB 0x10-0x01 -> 0x0000_000F) -> rsp0_result held at 0x0000_000F, req0_ready=0; port 1 SRA 0x8000_0000 by 4 -> 0xF800_0000 proceeds. Raising rsp0_ready re-enables port 0 the same cycle, with no bubble.
- Illegal op: port 1 op=0x09 -> rsp1_result=0, err_illegal_op=1 and sticky across further legal ops.
- Wrap and reset: preload op_count by issuing 65535 ops, one more -> op_count=0. Assert rst while rsp1_valid=1 -> rsp1_valid=0 immediately, err_illegal_op=0.
